// File: rtl/kv10_memory.sv
// KV10 main-memory responder: level-based read/write requests with configurable wait states.
// Ack is registered and held until the request drops; out-of-range or dual requests return page_fail.
module kv10_memory #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WORD_WIDTH  = 36,
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  read,
    input  logic                  write,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  read_ack,
    output logic                  write_ack,
    output logic                  page_fail
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [WORD_WIDTH-1:0] lat_data;
    logic                  lat_wr;

    logic                  latch_en, access, fault, release_ack;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [WORD_WIDTH-1:0] acc_data;
    logic                  acc_wr;
    logic                  in_range;
    logic [IDX_W-1:0]      acc_idx;

    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

    assign in_range = {1'b0, address} < MEM_LIMIT;
    assign acc_idx  = acc_addr[IDX_W-1:0];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        latch_en    = 1'b0;
        access      = 1'b0;
        fault       = 1'b0;
        release_ack = 1'b0;
        acc_addr    = lat_addr;
        acc_data    = lat_data;
        acc_wr      = lat_wr;
        case (state)
            IDLE: begin
                if (read && write) begin
                    fault     = 1'b1;
                    state_nxt = DONE;
                end else if (read || write) begin
                    if (!in_range) begin
                        fault     = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        latch_en = 1'b1;
                        if (WAIT_STATES == 0) begin
                            // Zero wait states: access straight from the inputs this edge
                            access    = 1'b1;
                            acc_addr  = address;
                            acc_data  = write_data;
                            acc_wr    = write;
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt   = WS_LOAD;
                            state_nxt = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!read && !write) begin
                    release_ack = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_wr    <= 1'b0;
            read_data <= '0;
            read_ack  <= 1'b0;
            write_ack <= 1'b0;
            page_fail <= 1'b0;
        end else begin
            if (latch_en) begin
                lat_addr <= address;
                lat_data <= write_data;
                lat_wr   <= write;
            end
            if (access) begin
                if (acc_wr) begin
                    write_ack <= 1'b1;
                end else begin
                    read_ack  <= 1'b1;
                    read_data <= mem[acc_idx];
                end
            end
            if (fault) begin
                page_fail <= 1'b1;
            end
            if (release_ack) begin
                read_ack  <= 1'b0;
                write_ack <= 1'b0;
                page_fail <= 1'b0;
            end
        end
    end

    // Storage is never reset; gating on reset drops any write in flight
    always_ff @(posedge clk) begin
        if (access && acc_wr && !reset) begin
            mem[acc_idx] <= acc_data;
        end
    end
endmodule
